// File: rtl/parametro_editor.sv
// Nine-field BCD parameter editor: one-hot field selection, edge-triggered inc/dec with
// per-field wrap, calendar-aware day limits, and a req/ack commit handshake to the RTC.
module parametro_editor (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [8:0]  Habilita,
    input  logic        inc,
    input  logic        dec,
    input  logic        Ld,
    input  logic [71:0] ld_data,
    input  logic        Listo_ht,
    input  logic        wr_ack,
    output logic [71:0] param_out,
    output logic        wr_req,
    output logic        commit_done
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state_q, state_d;
    logic [8:0][7:0] fields_q, fields_d;
    logic [8:0][7:0] ld_f;
    logic            inc_q, dec_q, listo_q;
    logic            inc_edge, dec_edge, listo_edge;
    logic            onehot;
    logic [3:0]      sel;
    logic [6:0]      dm_cur, dm_new;

    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        logic [6:0] t, r;
        t = v / 7'd10;
        r = v % 7'd10;
        return {t[3:0], r[3:0]};
    endfunction

    function automatic logic is_bcd(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [6:0] dmax_f(input logic [7:0] month, input logic [7:0] year);
        logic [6:0] y;
        y = bcd2bin(year);
        case (month)
            8'h02:                      return (y[1:0] == 2'd0) ? 7'd29 : 7'd28;
            8'h04, 8'h06, 8'h09, 8'h11: return 7'd30;
            default:                    return 7'd31;
        endcase
    endfunction

    function automatic logic [6:0] fmin(input logic [3:0] k);
        return (k == 4'd3 || k == 4'd4) ? 7'd1 : 7'd0;
    endfunction

    function automatic logic [6:0] fmax(input logic [3:0] k, input logic [6:0] dm);
        case (k)
            4'd2, 4'd8: return 7'd23;
            4'd3:       return dm;
            4'd4:       return 7'd12;
            4'd5:       return 7'd99;
            default:    return 7'd59;
        endcase
    endfunction

    // Day is range-checked against 31 here; the calendar clamp runs afterwards.
    function automatic logic [7:0] ld_fix(input logic [3:0] k, input logic [7:0] b);
        logic [6:0] v;
        v = bcd2bin(b);
        if (!is_bcd(b) || v < fmin(k) || v > fmax(k, 7'd31)) return bin2bcd(fmin(k));
        return b;
    endfunction

    function automatic logic [7:0] step_f(input logic [3:0] k, input logic [7:0] b,
                                          input logic up, input logic [6:0] dm);
        logic [6:0] cur, mn, mx, nv;
        cur = bcd2bin(b);
        mn  = fmin(k);
        mx  = fmax(k, dm);
        if (up) nv = (cur >= mx) ? mn : cur + 7'd1;
        else    nv = (cur <= mn) ? mx : cur - 7'd1;
        return bin2bcd(nv);
    endfunction

    assign ld_f        = ld_data;
    assign param_out   = fields_q;
    assign wr_req      = (state_q == REQ);
    assign commit_done = (state_q == DONE);
    assign inc_edge    = inc & ~inc_q;
    assign dec_edge    = dec & ~dec_q;
    assign listo_edge  = Listo_ht & ~listo_q;
    assign dm_cur      = dmax_f(fields_q[4], fields_q[5]);

    always_comb begin
        onehot = 1'b1;
        sel    = '0;
        case (Habilita)
            9'h001:  sel = 4'd0;
            9'h002:  sel = 4'd1;
            9'h004:  sel = 4'd2;
            9'h008:  sel = 4'd3;
            9'h010:  sel = 4'd4;
            9'h020:  sel = 4'd5;
            9'h040:  sel = 4'd6;
            9'h080:  sel = 4'd7;
            9'h100:  sel = 4'd8;
            default: onehot = 1'b0;
        endcase
    end

    always_comb begin
        fields_d = fields_q;
        dm_new   = dm_cur;
        if (state_q == IDLE) begin
            if (Ld) begin
                for (int unsigned k = 0; k < 9; k++)
                    fields_d[4'(k)] = ld_fix(4'(k), ld_f[4'(k)]);
            end else if (EN && onehot && (inc_edge ^ dec_edge)) begin
                fields_d[sel] = step_f(sel, fields_q[sel], inc_edge, dm_cur);
            end
            // Month/year changes (edit or load) may shrink dmax below the current day.
            dm_new = dmax_f(fields_d[4], fields_d[5]);
            if (bcd2bin(fields_d[3]) > dm_new) fields_d[3] = bin2bcd(dm_new);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (listo_edge) state_d = REQ;
            REQ:     if (wr_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            fields_q <= 72'h000000_00_01_01_000000;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            listo_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fields_q <= fields_d;
            inc_q    <= inc;
            dec_q    <= dec;
            listo_q  <= Listo_ht;
        end
    end

endmodule

// File: tb/tb_parametro_editor.sv
// Directed bench for parametro_editor: reset, wrap, calendar limits, guards and commit handshake.
module tb_parametro_editor;

    logic        clk = 1'b0;
    logic        rst, EN, inc, dec, Ld, Listo_ht, wr_ack;
    logic [8:0]  Habilita;
    logic [71:0] ld_data;
    logic [71:0] param_out;
    logic        wr_req, commit_done;

    int checks = 0;
    int errors = 0;

    localparam logic [71:0] RESET_V = 72'h000000_00_01_01_000000;

    parametro_editor dut (
        .clk(clk), .rst(rst), .EN(EN), .Habilita(Habilita), .inc(inc), .dec(dec),
        .Ld(Ld), .ld_data(ld_data), .Listo_ht(Listo_ht), .wr_ack(wr_ack),
        .param_out(param_out), .wr_req(wr_req), .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [71:0] v);
        Ld = 1'b1;
        ld_data = v;
        step();
        Ld = 1'b0;
    endtask

    task automatic pulse_dec();
        dec = 1'b1;
        step();
        dec = 1'b0;
    endtask

    initial begin
        rst = 1'b0; EN = 1'b0; inc = 1'b0; dec = 1'b0; Ld = 1'b0;
        Listo_ht = 1'b0; wr_ack = 1'b0; Habilita = '0; ld_data = '0;
        step(); step();
        chk("reset_param", param_out, RESET_V);
        chk1("reset_wr_req", wr_req, 1'b0);
        chk1("reset_commit", commit_done, 1'b0);
        rst = 1'b1;
        step();

        // Wrap on seconds
        load(72'h000000_00_01_01_000059);
        chk("ld_sec59", param_out, 72'h000000_00_01_01_000059);
        Habilita = 9'h001; EN = 1'b1;
        inc = 1'b1; step(); inc = 1'b0;
        chk("sec_inc_wrap", param_out, 72'h000000_00_01_01_000000);
        step();
        pulse_dec();
        chk("sec_dec_wrap", param_out, 72'h000000_00_01_01_000059);
        step();
        inc = 1'b1;
        repeat (10) step();
        inc = 1'b0;
        chk("sec_hold_once", param_out, 72'h000000_00_01_01_000000);
        step();

        // Calendar limits
        load(72'h000000_24_03_31_000000);
        Habilita = 9'h010;
        pulse_dec();
        chk("month_dec_leap", param_out, 72'h000000_24_02_29_000000);
        step();
        load(72'h000000_23_03_31_000000);
        pulse_dec();
        chk("month_dec_noleap", param_out, 72'h000000_23_02_28_000000);
        step();
        load(72'h000000_23_02_01_000000);
        Habilita = 9'h008;
        pulse_dec();
        chk("day_dec_wrap", param_out, 72'h000000_23_02_28_000000);
        step();
        Habilita = 9'h004;
        pulse_dec();
        chk("hour_dec_wrap", param_out, 72'h000000_23_02_28_230000);
        step();

        // Guards
        Habilita = 9'h003;
        inc = 1'b1; step(); inc = 1'b0;
        chk("multihot", param_out, 72'h000000_23_02_28_230000);
        step();
        Habilita = 9'h001; EN = 1'b0;
        inc = 1'b1; step(); inc = 1'b0;
        chk("en_low", param_out, 72'h000000_23_02_28_230000);
        step();
        EN = 1'b1;
        inc = 1'b1; dec = 1'b1; step(); inc = 1'b0; dec = 1'b0;
        chk("inc_dec_both", param_out, 72'h000000_23_02_28_230000);
        step();
        load(72'h000000_23_02_28_23007A);
        chk("ld_nonbcd", param_out, 72'h000000_23_02_28_230000);
        load(72'h000000_23_13_31_000000);
        chk("ld_bad_month_day", param_out, 72'h000000_23_01_31_000000);
        load(72'h000000_23_02_31_230000);
        chk("ld_day_clamp", param_out, 72'h000000_23_02_28_230000);

        // Commit handshake
        Listo_ht = 1'b1; step(); Listo_ht = 1'b0;
        chk1("req_high", wr_req, 1'b1);
        inc = 1'b1; step(); inc = 1'b0;
        chk("frozen_in_req", param_out, 72'h000000_23_02_28_230000);
        chk1("req_still", wr_req, 1'b1);
        repeat (3) step();
        chk1("no_commit_yet", commit_done, 1'b0);
        wr_ack = 1'b1; step();
        chk1("ack_req_low", wr_req, 1'b0);
        chk1("ack_commit", commit_done, 1'b1);
        step();
        chk1("commit_one_cycle", commit_done, 1'b0);
        step();
        chk1("ack_held_no_req", wr_req, 1'b0);
        chk1("ack_held_no_commit", commit_done, 1'b0);
        wr_ack = 1'b0;
        step();

        // Reset mid-handshake
        Listo_ht = 1'b1; step(); Listo_ht = 1'b0;
        chk1("req2_high", wr_req, 1'b1);
        load(72'h000000_11_11_11_111111);
        chk("ld_in_req", param_out, 72'h000000_23_02_28_230000);
        rst = 1'b0; step(); rst = 1'b1;
        chk1("rst_req_low", wr_req, 1'b0);
        chk("rst_param", param_out, RESET_V);
        wr_ack = 1'b1; step();
        chk1("late_ack_commit", commit_done, 1'b0);
        chk1("late_ack_req", wr_req, 1'b0);
        step();
        chk1("late_ack_commit2", commit_done, 1'b0);
        wr_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parametro_editor.md
# parametro_editor

Holds the nine editable clock/date/timer parameters and applies up/down edits to the parameter whose enable line is active on the 9-bit one-hot `Habilita` bus from the parameter selector. It is the consumer end of that selection interface. It turns the selector's enables plus the inc/dec buttons into BCD register updates with per-field wrap-around and calendar-aware day limits. When the selector signals completion, it offers the edited set to the RTC write path through a req/ack handshake.

## Interface
Parameters: none; field ranges are fixed.

- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `EN`  in  1  edit enable; inc/dec are ignored while 0
- `Habilita`  in  9  one-hot field select: bit0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year, 6 timer sec, 7 timer min, 8 timer hour
- `inc`  in  1  increment button, level; acts on rising edge
- `dec`  in  1  decrement button, level; acts on rising edge
- `Ld`  in  1  load all fields from `ld_data`
- `ld_data`  in  72  packed BCD, field k at bits [8k+7:8k]
- `Listo_ht`  in  1  edit-complete strobe from the selector
- `wr_ack`  in  1  write path has consumed `param_out`
- `param_out`  out  72  packed BCD of all fields, same layout as `ld_data`
- `wr_req`  out  1  write request, held high until acknowledged
- `commit_done`  out  1  one-cycle pulse after the acknowledge

## Operation
- **Field ranges, min..max (BCD):**
  - sec, min, timer sec, timer min: 00..59
  - hour, timer hour: 00..23
  - day: 01..dmax
  - month: 01..12
  - year: 00..99
- **dmax:**
  - 31 for months 1, 3, 5, 7, 8, 10, 12
  - 30 for months 4, 6, 9, 11
  - February: 29 if year mod 4 == 0, else 28
- **Edge detection:**
  - Internal registers `inc_q` and `dec_q` sample `inc` and `dec` every cycle.
  - Edge = `inc & ~inc_q` (likewise for dec).
  - One step per edge; holding a button does not repeat.
- **Edit:** applies on an edge only when `EN=1`, `Habilita` has exactly one bit set, and FSM is IDLE.
  - inc at max wraps to min.
  - dec at min wraps to max; day dec from 01 wraps to the current dmax.
- **Simultaneous inc and dec edges:** no change.
- **Zero or multi-hot `Habilita`:** no change.
- **Day clamp:** if a month or year edit makes day > new dmax, day is set to the new dmax in the same update.
  - Example: 31/03 → dec month → 29/02 when year mod 4 == 0.
- **Ld:**
  - Has priority over edits and loads all fields.
  - Out-of-range or non-BCD field values are replaced by that field's minimum.
  - A day above dmax is clamped.
  - Ignored while the FSM is not IDLE.
- **FSM states:**
  - **IDLE:** a rising edge of `Listo_ht` (internally edge-detected) moves to REQ.
  - **REQ:** `wr_req=1`; fields are frozen; edits and Ld are ignored. `wr_ack=1` moves to DONE.
  - **DONE:** `commit_done=1` for one cycle, then IDLE.
- `wr_ack` outside REQ is ignored.
- `param_out` always reflects the registered fields; it is combinational from registers, with no extra delay.

## Timing
- **Reset values:**
  - All fields 00, except day = 01 and month = 01.
  - `wr_req=0`, `commit_done=0`, FSM = IDLE, edge registers = 0.
- **Reset mid-operation:** reset in any state, including REQ with `wr_req` high, returns everything to the reset values on that edge. `wr_req` drops the next cycle.
- **Edit latency:** `inc` goes high in cycle n (low in n-1) → `param_out` shows the new value after the n clock edge, i.e. visible in cycle n+1.
- **Ld latency:** `Ld` high in cycle n → loaded values visible in n+1.
- **Commit sequence:**
  - `Listo_ht` edge in cycle n → `wr_req` high from n+1.
  - `wr_ack` sampled high in cycle m ≥ n+1 → `wr_req` low and `commit_done` high in m+1 → `commit_done` low in m+2.
  - A new commit is accepted from m+2.
- `wr_ack` may be held for many cycles; only one commit results.

## Test plan
1. **Reset:** `rst=0` for 2 cycles → `param_out` = 0x00_00_00_00_01_01_00_00_00 (field 8 first), `wr_req=0`, `commit_done=0`.
2. **Wrap:** `Habilita=9'b000000001`, `EN=1`, sec=59, one inc pulse → sec=00 one cycle later. Then one dec pulse → sec=59. Hold inc high 10 cycles → exactly one increment.
3. **Calendar:** load year=24, month=03, day=31; `Habilita=bit4`, dec → month=02, day=29. Load year=23 and repeat → day=28. With day=01, `Habilita=bit3`, dec → day=28.
4. **Guards:**
   - `Habilita=9'b000000011` with inc → no change.
   - `EN=0` with inc → no change.
   - inc and dec rising together → no change.
   - Ld with field0=0x7A → sec=00.
5. **Handshake:** `Listo_ht` pulse → `wr_req=1` next cycle. Inc during REQ → no change. `wr_ack` after 5 cycles → `wr_req=0` and `commit_done=1` for exactly one cycle.
6. **Reset mid-handshake:** `rst=0` while `wr_req=1` → `wr_req=0` and fields at reset values next cycle. A later `wr_ack` produces no `commit_done`.
